// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side streams and FIFO write-port signals shared by the round-robin write arbiter.
// The master modport is the arbiter's view; the slave modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    in_valid;
    logic [NREQ*DW-1:0] in_data;
    logic [NREQ-1:0]    in_ready;
    logic               full;
    logic               wr_en;
    logic [DW-1:0]      wr_data;
    logic [NREQ-1:0]    grant;
    logic               busy;

    modport master (
        input  in_valid, in_data, full,
        output in_ready, wr_en, wr_data, grant, busy
    );

    modport slave (
        output in_valid, in_data, full,
        input  in_ready, wr_en, wr_data, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters,
// granting bursts of up to BURST beats with a combinational, full-aware datapath.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input logic               clk,
    input logic               reset_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] LastBeat = CW'(BURST - 1);
    localparam logic [IW-1:0] LastReq  = IW'(NREQ - 1);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]   pick;
    logic            pick_valid;
    logic [IW-1:0]   cand;
    logic            xfer;
    logic [NREQ-1:0] in_ready;
    logic [NREQ-1:0] grant;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            busy;

    // Scan from farthest to nearest so the nearest valid after last wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = IW'((32'(last_q) + k) % NREQ);
            if (bus.in_valid[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        xfer       = 1'b0;
        in_ready   = '0;
        grant      = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        busy       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    idx_d      = pick;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                busy            = 1'b1;
                grant[idx_q]    = 1'b1;
                in_ready[idx_q] = ~bus.full;
                xfer            = bus.in_valid[idx_q] & ~bus.full;
                wr_en           = xfer;
                wr_data         = bus.in_data[32'(idx_q) * DW +: DW];
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
                if (!bus.in_valid[idx_q] || (xfer && beat_cnt_q == LastBeat)) begin
                    state_d = StIdle;
                    last_d  = idx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_q     <= LastReq;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.grant    = grant;
    assign bus.wr_en    = wr_en;
    assign bus.wr_data  = wr_data;
    assign bus.busy     = busy;
endmodule
